// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one registered ALU through an IDLE/EXEC/RESP FSM.
// Latency: grant in IDLE, operate in EXEC, response held in RESP (one op per 3 cycles peak).
// Backpressure: response held stable until rsp_ready; no new grant outside IDLE.
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties);
// otherwise ties are resolved round-robin, starting with requester 0 after reset.
module alu_arbiter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid0,
  input  logic         req_valid1,
  output logic         req_ready0,
  output logic         req_ready1,
  input  logic [N-1:0] req_a0,
  input  logic [N-1:0] req_b0,
  input  logic [N-1:0] req_a1,
  input  logic [N-1:0] req_b1,
  input  logic [3:0]   req_sel0,
  input  logic [3:0]   req_sel1,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_result,
  output logic         rsp_overflow,
  output logic         rsp_zero,
  output logic         rsp_negative
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Operands captured from the winning requester
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic [3:0]   sel_q, sel_d;
  logic         id_q, id_d;

  // Registered response
  logic [N-1:0] res_q, res_d;
  logic         ovf_q, ovf_d;
  logic         zero_q, zero_d;
  logic         neg_q, neg_d;
  logic         rid_q, rid_d;

  // Arbitration result and ALU combinational outputs
  logic         grant_vld;
  logic         grant_id;
  logic         accept;
  logic [N:0]   sum_w;
  logic [N:0]   diff_w;
  logic [N-1:0] alu_res;
  logic         alu_ovf;

`ifndef ALU_ARB_FIXED_PRIO_EN
  // Requester favoured on the next tie: the one not served last
  logic prio_q, prio_d;
`endif

  // Pick the winner among valid requesters
  always_comb begin
    grant_vld = req_valid0 | req_valid1;
`ifdef ALU_ARB_FIXED_PRIO_EN
    grant_id  = ~req_valid0;
`else
    if (req_valid0 && req_valid1) begin
      grant_id = prio_q;
    end else begin
      grant_id = ~req_valid0;
    end
`endif
  end

  // Carry/borrow come out of bit N of the widened sum/difference
  assign sum_w  = {1'b0, a_q} + {1'b0, b_q};
  assign diff_w = {1'b0, a_q} - {1'b0, b_q};

  // ALU on the latched operands; unmapped opcodes give zero
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (sel_q)
      4'b0000: begin
        alu_res = sum_w[N-1:0];
        alu_ovf = sum_w[N];
      end
      4'b0001: begin
        alu_res = diff_w[N-1:0];
        alu_ovf = diff_w[N];
      end
      4'b0100: alu_res = a_q & b_q;
      4'b0101: alu_res = a_q | b_q;
      4'b0110: alu_res = ~(a_q & b_q);
      4'b0111: alu_res = ~(a_q | b_q);
      4'b1000: alu_res = a_q ^ b_q;
      4'b1001: alu_res = ~(a_q ^ b_q);
      4'b1010: alu_res = ~a_q;
      default: alu_res = '0;
    endcase
  end

  // FSM next state, grant outputs, operand capture and response load
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sel_d      = sel_q;
    id_d       = id_q;
    res_d      = res_q;
    ovf_d      = ovf_q;
    zero_d     = zero_q;
    neg_d      = neg_q;
    rid_d      = rid_q;
    req_ready0 = 1'b0;
    req_ready1 = 1'b0;
    accept     = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_vld && !rst) begin
          accept     = 1'b1;
          req_ready0 = ~grant_id;
          req_ready1 = grant_id;
          a_d        = grant_id ? req_a1 : req_a0;
          b_d        = grant_id ? req_b1 : req_b0;
          sel_d      = grant_id ? req_sel1 : req_sel0;
          id_d       = grant_id;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_res;
        ovf_d   = alu_ovf;
        zero_d  = (alu_res == '0);
        neg_d   = alu_res[N-1];
        rid_d   = id_q;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  // Pointer moves to the other requester only when an operation is accepted
  always_comb begin
    prio_d = prio_q;
    if (accept) begin
      prio_d = ~grant_id;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end
`endif

  // State, operand and response registers; reset drops any in-flight op
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      id_q    <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      rid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      id_q    <= id_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      rid_q   <= rid_d;
    end
  end

  assign rsp_valid    = (state_q == RESP);
  assign rsp_id       = rid_q;
  assign rsp_result   = res_q;
  assign rsp_overflow = ovf_q;
  assign rsp_zero     = zero_q;
  assign rsp_negative = neg_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level model checked every cycle on the falling edge,
// plus hand-computed literal responses compared at each response handshake.
`timescale 1ns/1ps
module tb_alu_arbiter;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid0, req_valid1;
  logic         req_ready0, req_ready1;
  logic [N-1:0] req_a0, req_b0, req_a1, req_b1;
  logic [3:0]   req_sel0, req_sel1;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [N-1:0] rsp_result;
  logic         rsp_overflow, rsp_zero, rsp_negative;

  always #5 clk = ~clk;

  alu_arbiter #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid0(req_valid0), .req_valid1(req_valid1),
    .req_ready0(req_ready0), .req_ready1(req_ready1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_sel0(req_sel0), .req_sel1(req_sel1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
    .rsp_zero(rsp_zero), .rsp_negative(rsp_negative)
  );

  typedef struct packed {
    logic         id;
    logic [N-1:0] res;
    logic         ov;
    logic         z;
    logic         ng;
  } rsp_t;

  typedef struct packed {
    logic         id;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   sel;
    logic [N-1:0] res;
    logic         ov;
    logic         z;
    logic         ng;
  } vec_t;

  // Reference ALU written with plain integer arithmetic
  function automatic rsp_t alu_ref(logic id, logic [N-1:0] a, logic [N-1:0] b, logic [3:0] sel);
    longint ua, ub, m, r;
    rsp_t o;
    ua = longint'(a);
    ub = longint'(b);
    m  = (longint'(1) << N) - 1;
    o.ov = 1'b0;
    case (sel)
      4'd0: begin r = ua + ub; o.ov = (r > m); end
      4'd1: begin r = ua - ub; o.ov = (ua < ub); end
      4'd4: r = ua & ub;
      4'd5: r = ua | ub;
      4'd6: r = ~(ua & ub);
      4'd7: r = ~(ua | ub);
      4'd8: r = ua ^ ub;
      4'd9: r = ~(ua ^ ub);
      4'd10: r = ~ua;
      default: r = 0;
    endcase
    r = r & m;
    o.res = r[N-1:0];
    o.z   = (r == 0);
    o.ng  = o.res[N-1];
    o.id  = id;
    return o;
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: busy with an op, edges since acceptance, expected response, last served
  bit   m_busy = 1'b0;
  int   m_age  = 0;
  bit   m_last = 1'b1;
  rsp_t m_exp  = '0;
  bit   er0, er1, ev, tie_win;

  // Literal expectations handed over from the stimulus process
  rsp_t lit_exp = '0;
  int   lit_seq = 0;
  int   lit_done = 0;
  int   lit_age = 0;

  // Per-cycle compare against the model, then advance the model
  always @(negedge clk) begin
    er0 = 1'b0;
    er1 = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    tie_win = 1'b0;
`else
    tie_win = ~m_last;
`endif
    if (!rst && !m_busy) begin
      if (req_valid0 && req_valid1) begin
        er0 = ~tie_win;
        er1 = tie_win;
      end else begin
        er0 = req_valid0;
        er1 = req_valid1;
      end
    end
    ev = !rst && m_busy && (m_age == 2);
    chk("req_ready0", req_ready0, er0);
    chk("req_ready1", req_ready1, er1);
    chk("rsp_valid", rsp_valid, ev);
    if (rst) begin
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_result", rsp_result, 0);
      chk("rst_rsp_overflow", rsp_overflow, 0);
      chk("rst_rsp_zero", rsp_zero, 0);
      chk("rst_rsp_negative", rsp_negative, 0);
    end else if (ev) begin
      chk("rsp_id", rsp_id, m_exp.id);
      chk("rsp_result", rsp_result, m_exp.res);
      chk("rsp_overflow", rsp_overflow, m_exp.ov);
      chk("rsp_zero", rsp_zero, m_exp.z);
      chk("rsp_negative", rsp_negative, m_exp.ng);
    end
    if (lit_done != lit_seq) begin
      if (!rst && rsp_valid && rsp_ready) begin
        chk("lit_id", rsp_id, lit_exp.id);
        chk("lit_result", rsp_result, lit_exp.res);
        chk("lit_overflow", rsp_overflow, lit_exp.ov);
        chk("lit_zero", rsp_zero, lit_exp.z);
        chk("lit_negative", rsp_negative, lit_exp.ng);
        lit_done = lit_seq;
        lit_age  = 0;
      end else begin
        lit_age++;
        if (lit_age > 40) begin
          chk("lit_response_timeout", 0, 1);
          lit_done = lit_seq;
          lit_age  = 0;
        end
      end
    end
    if (rst) begin
      m_busy = 1'b0;
      m_last = 1'b1;
    end else if (er0 || er1) begin
      m_exp  = er1 ? alu_ref(1'b1, req_a1, req_b1, req_sel1)
                   : alu_ref(1'b0, req_a0, req_b0, req_sel0);
      m_busy = 1'b1;
      m_age  = 1;
      m_last = er1;
    end else if (m_busy) begin
      if (m_age < 2) m_age++;
      else if (rsp_ready) m_busy = 1'b0;
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_lit(logic id, logic [N-1:0] res, logic ov, logic z, logic ng);
    lit_exp = {id, res, ov, z, ng};
    lit_seq++;
  endtask

  task automatic wait_lit();
    int n;
    n = 0;
    while (lit_done != lit_seq && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
  endtask

  task automatic drive(logic id, logic [N-1:0] a, logic [N-1:0] b, logic [3:0] sel);
    if (id) begin
      req_a1 = a; req_b1 = b; req_sel1 = sel; req_valid1 = 1'b1;
    end else begin
      req_a0 = a; req_b0 = b; req_sel0 = sel; req_valid0 = 1'b1;
    end
  endtask

  vec_t vecs [12] = '{
    '{1'b0, 8'h05, 8'h03, 4'h0, 8'h08, 1'b0, 1'b0, 1'b0},
    '{1'b1, 8'h03, 8'h05, 4'h1, 8'hFE, 1'b1, 1'b0, 1'b1},
    '{1'b0, 8'hAA, 8'h55, 4'h3, 8'h00, 1'b0, 1'b1, 1'b0},
    '{1'b1, 8'hFF, 8'h01, 4'h0, 8'h00, 1'b1, 1'b1, 1'b0},
    '{1'b0, 8'hF0, 8'h3C, 4'h8, 8'hCC, 1'b0, 1'b0, 1'b1},
    '{1'b1, 8'hFF, 8'h0F, 4'h6, 8'hF0, 1'b0, 1'b0, 1'b1},
    '{1'b0, 8'h0F, 8'h99, 4'hA, 8'hF0, 1'b0, 1'b0, 1'b1},
    '{1'b1, 8'hA0, 8'h05, 4'h5, 8'hA5, 1'b0, 1'b0, 1'b1},
    '{1'b0, 8'h10, 8'h10, 4'h1, 8'h00, 1'b0, 1'b1, 1'b0},
    '{1'b1, 8'h0F, 8'hF0, 4'h7, 8'h00, 1'b0, 1'b1, 1'b0},
    '{1'b0, 8'hC3, 8'h0F, 4'h9, 8'h33, 1'b0, 1'b0, 1'b0},
    '{1'b1, 8'hFF, 8'h81, 4'h4, 8'h81, 1'b0, 1'b0, 1'b1}
  };

  initial begin
    int n;
    logic rr_id;
    rst = 1'b1;
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    req_sel0 = '0; req_sel1 = '0;
    rsp_ready = 1'b1;
    cyc(3);
    rst = 1'b0;

    // Single-requester operations across the opcode map
    for (int k = 0; k < 12; k++) begin
      expect_lit(vecs[k].id, vecs[k].res, vecs[k].ov, vecs[k].z, vecs[k].ng);
      drive(vecs[k].id, vecs[k].a, vecs[k].b, vecs[k].sel);
      cyc(1);
      req_valid0 = 1'b0;
      req_valid1 = 1'b0;
      wait_lit();
    end

    // Response held for 5 cycles while other requests come and go
    rsp_ready = 1'b0;
    expect_lit(1'b0, 8'h33, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h22, 8'h11, 4'h0);
    cyc(1);
    req_valid0 = 1'b0;
    n = 0;
    while (!rsp_valid && n < 10) begin
      cyc(1);
      n++;
    end
    drive(1'b1, 8'h44, 8'h04, 4'h1);
    drive(1'b0, 8'h01, 8'h01, 4'h0);
    cyc(2);
    req_valid0 = 1'b0;
    cyc(3);
    rsp_ready = 1'b1;
    wait_lit();
    expect_lit(1'b1, 8'h40, 1'b0, 1'b0, 1'b0);
    cyc(1);
    req_valid1 = 1'b0;
    wait_lit();

    // Both requesters valid continuously
    for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      rr_id = 1'b0;
`else
      rr_id = k[0];
`endif
      expect_lit(rr_id, rr_id ? 8'h04 : 8'h02, 1'b0, 1'b0, 1'b0);
      if (k == 0) begin
        drive(1'b0, 8'h01, 8'h01, 4'h0);
        drive(1'b1, 8'h02, 8'h02, 4'h0);
      end
      wait_lit();
    end
    req_valid0 = 1'b0;
    req_valid1 = 1'b0;
    cyc(2);

    // Reset during EXEC discards the op and restores requester 0 priority
    drive(1'b0, 8'h10, 8'h20, 4'h0);
    cyc(1);
    req_valid0 = 1'b0;
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(3);
    expect_lit(1'b0, 8'h07, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h03, 8'h04, 4'h0);
    drive(1'b1, 8'h05, 8'h05, 4'h0);
    wait_lit();
    req_valid0 = 1'b0;
    req_valid1 = 1'b0;
    cyc(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
